// File: rtl/vector_apu_arbiter_if.sv
// Bus bundle between NUM_REQ APU requesters, the arbiter and one vector decoder.
// The arbiter attaches through the slave modport; the surrounding system drives the master side.
interface vector_apu_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ*96-1:0] req_operands_i;
  logic [NUM_REQ*6-1:0]  req_op_i;
  logic [NUM_REQ*15-1:0] req_flags_i;
  logic [NUM_REQ-1:0]    gnt_o;
  logic [NUM_REQ-1:0]    rvalid_o;
  logic [31:0]           result_o;

  logic                  apu_req_o;
  logic [95:0]           apu_operands_o;
  logic [5:0]            apu_op_o;
  logic [14:0]           apu_flags_o;
  logic                  apu_gnt_i;
  logic                  apu_rvalid_i;
  logic [31:0]           apu_result_i;

  logic                  busy_o;
  logic [IDX_W-1:0]      owner_o;
  logic                  err_o;

  modport slave (
    input  req_i, req_operands_i, req_op_i, req_flags_i,
    input  apu_gnt_i, apu_rvalid_i, apu_result_i,
    output gnt_o, rvalid_o, result_o,
    output apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
    output busy_o, owner_o, err_o
  );

  modport master (
    output req_i, req_operands_i, req_op_i, req_flags_i,
    output apu_gnt_i, apu_rvalid_i, apu_result_i,
    input  gnt_o, rvalid_o, result_o,
    input  apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
    input  busy_o, owner_o, err_o
  );
endinterface

// File: rtl/vector_apu_arbiter.sv
// Shares one vector decoder APU port between NUM_REQ cores, one instruction at a time.
// Define APU_ARB_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module vector_apu_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input logic                   clk,
  input logic                   reset,
  vector_apu_arbiter_if.slave   io_bus
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e           r_state, w_state_next;
  logic [IDX_W-1:0] r_owner, w_owner_next;
  logic [IDX_W-1:0] w_winner, w_sel, w_rr_ptr;
  logic             r_err, w_err_next;
  logic             w_any, w_handshake;

`ifdef APU_ARB_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_rr_next;

  assign w_rr_next = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset)            r_rr_ptr <= '0;
    else if (w_handshake) r_rr_ptr <= w_rr_next;
  end

  assign w_rr_ptr = r_rr_ptr;
`endif

  assign w_any = |io_bus.req_i;

  // First pending requester at or above the pointer, wrapping; the lowest offset is written last.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    w_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(w_rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (io_bus.req_i[cand]) w_winner = cand;
    end
  end

  // Payload stays on the owner while busy so the captured instruction remains visible.
  assign w_sel                 = (r_state == S_BUSY) ? r_owner : w_winner;
  assign io_bus.apu_operands_o = io_bus.req_operands_i[int'(w_sel)*96 +: 96];
  assign io_bus.apu_op_o       = io_bus.req_op_i[int'(w_sel)*6 +: 6];
  assign io_bus.apu_flags_o    = io_bus.req_flags_i[int'(w_sel)*15 +: 15];
  assign io_bus.result_o       = io_bus.apu_result_i;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_next       = r_state;
    w_owner_next       = r_owner;
    w_err_next         = r_err;
    w_handshake        = 1'b0;
    io_bus.apu_req_o   = 1'b0;
    io_bus.gnt_o       = '0;
    io_bus.rvalid_o    = '0;

    case (r_state)
      S_IDLE: begin
        io_bus.apu_req_o = w_any;
        if (w_any) io_bus.gnt_o[w_winner] = io_bus.apu_gnt_i;
        w_handshake = w_any & io_bus.apu_gnt_i;
        if (w_handshake) begin
          w_state_next = S_BUSY;
          w_owner_next = w_winner;
        end
        if (io_bus.apu_rvalid_i) w_err_next = 1'b1;
      end
      S_BUSY: begin
        if (io_bus.apu_rvalid_i) begin
          io_bus.rvalid_o[r_owner] = 1'b1;
          w_state_next             = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Handshake outputs are forced quiet while reset is asserted.
    if (reset) begin
      io_bus.apu_req_o = 1'b0;
      io_bus.gnt_o     = '0;
      io_bus.rvalid_o  = '0;
      w_handshake      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_err   <= w_err_next;
    end
  end

  assign io_bus.busy_o  = (r_state == S_BUSY);
  assign io_bus.owner_o = r_owner;
  assign io_bus.err_o   = r_err;

endmodule

// File: tb/tb_vector_apu_arbiter.sv
// Self-checking bench for vector_apu_arbiter: directed vector table, hand sequences,
// then random traffic against a cycle-level reference model of the arbitration rules.
module tb_vector_apu_arbiter;
  localparam int N = 2;

`ifdef APU_ARB_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_apu_arbiter_if #(.NUM_REQ(N)) bus ();

  vector_apu_arbiter #(.NUM_REQ(N)) dut (
    .clk    (clk),
    .reset  (rst),
    .io_bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  bit m_err;

  typedef struct {
    logic [N-1:0] req;
    logic         gnt;
    logic         rv;
    logic [31:0]  res;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_rv;
    logic         e_req;
    logic         e_busy;
    int           e_owner;
    logic         e_err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [N-1:0] req, logic gnt, logic rv, logic [31:0] res,
                              logic [N-1:0] e_gnt, logic [N-1:0] e_rv, logic e_req,
                              logic e_busy, int e_owner, logic e_err);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.res = res;
    v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_req = e_req;
    v.e_busy = e_busy; v.e_owner = e_owner; v.e_err = e_err;
    return v;
  endfunction

  // Rotate the request vector so the search starts at ptr, then take the lowest set bit.
  function automatic int pick(logic [N-1:0] req, int ptr);
    logic [2*N-1:0] rot;
    rot = {req, req} >> ptr;
    for (int k = 0; k < N; k++) if (rot[k]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic apply(input logic [N-1:0] req, input logic g, input logic rv, input logic [31:0] res);
    bus.req_i        = req;
    bus.apu_gnt_i    = g;
    bus.apu_rvalid_i = rv;
    bus.apu_result_i = res;
    for (int k = 0; k < N * 3; k++) bus.req_operands_i[k*32 +: 32] = $urandom;
    for (int k = 0; k < N; k++) begin
      bus.req_op_i[k*6 +: 6]     = 6'($urandom);
      bus.req_flags_i[k*15 +: 15] = 15'($urandom);
    end
    #1;
  endtask

  task automatic tick();
    int w;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_err = 0;
    end else if (!m_busy) begin
      if (|bus.req_i && bus.apu_gnt_i) begin
        w       = pick(bus.req_i, RR ? m_ptr : 0);
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_busy  = 1;
      end
      if (bus.apu_rvalid_i) m_err = 1;
    end else if (bus.apu_rvalid_i) begin
      m_busy = 0;
    end
    #1;
  endtask

  task automatic compare_model(input string tag);
    logic [N-1:0] e_gnt, e_rv;
    logic         e_req;
    int           sel;
    e_gnt = '0; e_rv = '0; e_req = 1'b0;
    if (m_busy) begin
      sel = m_owner;
      if (bus.apu_rvalid_i) e_rv = N'(1) << m_owner;
    end else begin
      sel   = (|bus.req_i) ? pick(bus.req_i, RR ? m_ptr : 0) : 0;
      e_req = |bus.req_i;
      if (|bus.req_i && bus.apu_gnt_i) e_gnt = N'(1) << sel;
    end
    if (rst) begin
      e_gnt = '0; e_rv = '0; e_req = 1'b0;
    end
    check({tag, " gnt"},      bus.gnt_o,          e_gnt);
    check({tag, " rvalid"},   bus.rvalid_o,       e_rv);
    check({tag, " apu_req"},  bus.apu_req_o,      e_req);
    check({tag, " busy"},     bus.busy_o,         m_busy);
    check({tag, " owner"},    bus.owner_o,        m_owner);
    check({tag, " err"},      bus.err_o,          m_err);
    check({tag, " operands"}, bus.apu_operands_o, bus.req_operands_i[sel*96 +: 96]);
    check({tag, " op"},       bus.apu_op_o,       bus.req_op_i[sel*6 +: 6]);
    check({tag, " flags"},    bus.apu_flags_o,    bus.req_flags_i[sel*15 +: 15]);
    check({tag, " result"},   bus.result_o,       bus.apu_result_i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table: each row is one cycle, expected outputs written out by hand.
    vecs[0]  = mk(2'b01, 1, 0, 32'h0,  2'b01, 2'b00, 1, 0, 0, 0);
    vecs[1]  = mk(2'b00, 0, 1, 32'h10, 2'b00, 2'b01, 0, 1, 0, 0);
    vecs[2]  = mk(2'b11, 1, 0, 32'h0,  RR ? 2'b10 : 2'b01, 2'b00, 1, 0, 0, 0);
    vecs[3]  = mk(2'b11, 0, 0, 32'h0,  2'b00, 2'b00, 0, 1, RR ? 1 : 0, 0);
    vecs[4]  = mk(2'b11, 0, 1, 32'hA5, 2'b00, RR ? 2'b10 : 2'b01, 0, 1, RR ? 1 : 0, 0);
    vecs[5]  = mk(2'b11, 1, 0, 32'h0,  2'b01, 2'b00, 1, 0, RR ? 1 : 0, 0);
    vecs[6]  = mk(2'b10, 0, 0, 32'h0,  2'b00, 2'b00, 0, 1, 0, 0);
    vecs[7]  = mk(2'b10, 0, 0, 32'h0,  2'b00, 2'b00, 0, 1, 0, 0);
    vecs[8]  = mk(2'b10, 0, 0, 32'h0,  2'b00, 2'b00, 0, 1, 0, 0);
    vecs[9]  = mk(2'b10, 0, 1, 32'h10, 2'b00, 2'b01, 0, 1, 0, 0);
    vecs[10] = mk(2'b10, 1, 0, 32'h0,  2'b10, 2'b00, 1, 0, 0, 0);
    vecs[11] = mk(2'b00, 0, 0, 32'h0,  2'b00, 2'b00, 0, 1, 1, 0);
    vecs[12] = mk(2'b00, 0, 1, 32'h77, 2'b00, 2'b10, 0, 1, 1, 0);
    vecs[13] = mk(2'b00, 1, 1, 32'h0,  2'b00, 2'b00, 0, 0, 1, 0);
    vecs[14] = mk(2'b00, 1, 0, 32'h0,  2'b00, 2'b00, 0, 0, 1, 1);

    // Reset: handshake outputs quiet even with every input active.
    m_busy = 0; m_owner = 0; m_ptr = 0; m_err = 0;
    rst = 1'b1;
    apply('1, 1'b1, 1'b1, 32'h0);
    tick();
    compare_model("rst");
    tick();
    compare_model("rst2");
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].res);
      check($sformatf("v%0d gnt", i),    bus.gnt_o,     vecs[i].e_gnt);
      check($sformatf("v%0d rvalid", i), bus.rvalid_o,  vecs[i].e_rv);
      check($sformatf("v%0d apu_req", i), bus.apu_req_o, vecs[i].e_req);
      check($sformatf("v%0d busy", i),   bus.busy_o,    vecs[i].e_busy);
      check($sformatf("v%0d owner", i),  bus.owner_o,   vecs[i].e_owner);
      check($sformatf("v%0d err", i),    bus.err_o,     vecs[i].e_err);
      check($sformatf("v%0d result", i), bus.result_o,  vecs[i].res);
      compare_model($sformatf("v%0d model", i));
      tick();
    end

    // Reset while busy with owner 1: everything returns to its reset state.
    apply(2'b10, 1'b1, 1'b0, 32'h0);
    check("rb grant1", bus.gnt_o, 2'b10);
    tick();
    check("rb busy", bus.busy_o, 1'b1);
    check("rb owner1", bus.owner_o, 1'b1);
    check("rb err_sticky", bus.err_o, 1'b1);
    rst = 1'b1;
    apply(2'b11, 1'b1, 1'b1, 32'h5);
    check("rb rst gnt", bus.gnt_o, 2'b00);
    check("rb rst rvalid", bus.rvalid_o, 2'b00);
    check("rb rst apu_req", bus.apu_req_o, 1'b0);
    tick();
    rst = 1'b0;
    apply(2'b11, 1'b1, 1'b0, 32'h0);
    check("rb post busy", bus.busy_o, 1'b0);
    check("rb post owner", bus.owner_o, 1'b0);
    check("rb post err", bus.err_o, 1'b0);
    check("rb post gnt0", bus.gnt_o, 2'b01);
    compare_model("rb post");
    tick();
    apply(2'b00, 1'b0, 1'b1, 32'h0);
    compare_model("rb done");
    tick();

    // Random traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      logic rv;
      rst = ($urandom_range(0, 99) == 0);
      rv  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      apply(N'($urandom), ($urandom_range(0, 3) != 0), rv, $urandom);
      compare_model($sformatf("rnd%0d", c));
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
